// File: rtl/pq_ingress.sv
// Ingress stage for sr_pq: round-robin merge of two producers into a small FIFO that drains into the PQ insert port.
// Optional statistics outputs (hwm, stall_cnt, bp_cnt) are built when PQ_INGRESS_STATS_EN is defined.
module pq_ingress #(
  parameter int KW    = 4,
  parameter int VW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      s0_valid,
  input  logic [KW+VW-1:0]          s0_data,
  output logic                      s0_ready,
  input  logic                      s1_valid,
  input  logic [KW+VW-1:0]          s1_data,
  output logic                      s1_ready,
  output logic                      pq_ivalid,
  output logic [KW+VW-1:0]          pq_idata,
  input  logic                      pq_full,
  output logic [$clog2(DEPTH):0]    count
`ifdef PQ_INGRESS_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]    hwm,
  output logic [15:0]               stall_cnt,
  output logic [15:0]               bp_cnt
`endif
);

  localparam int DW = KW + VW;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          last_gnt;
  logic          full;
  logic          empty;
  logic          grant0;
  logic          grant1;
  logic          push;
  logic          pop;
  logic [DW-1:0] push_data;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign pq_ivalid = !empty;
  assign pq_idata  = mem[rd_ptr];

  // last_gnt=1 means producer 1 won the most recent push, so producer 0 wins the next tie
  always_comb begin
    grant0 = s0_valid && (!s1_valid || last_gnt);
    grant1 = s1_valid && (!s0_valid || !last_gnt);
  end

  // rst_n gating keeps ready low while reset is held even though count is already zero
  assign s0_ready  = rst_n && !flush && !full && grant0;
  assign s1_ready  = rst_n && !flush && !full && grant1;
  assign push      = s0_ready || s1_ready;
  assign push_data = s1_ready ? s1_data : s0_data;
  assign pop       = pq_ivalid && !pq_full && !flush;

  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count_q + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      last_gnt <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
        last_gnt    <= s1_ready;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_nxt;
    end
  end

`ifdef PQ_INGRESS_STATS_EN
  logic stall;
  logic bp;

  assign stall = pq_ivalid && pq_full;
  assign bp    = (s0_valid && !s0_ready) || (s1_valid && !s1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm       <= '0;
      stall_cnt <= '0;
      bp_cnt    <= '0;
    end else if (flush) begin
      hwm       <= '0;
      stall_cnt <= '0;
      bp_cnt    <= '0;
    end else begin
      if (count_nxt > hwm) begin
        hwm <= count_nxt;
      end
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (bp && (bp_cnt != 16'hFFFF)) begin
        bp_cnt <= bp_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pq_ingress.sv
// Directed bench for pq_ingress with an acceptance-order scoreboard checked at every PQ insert.
module tb_pq_ingress;

  localparam int KW = 4;
  localparam int VW = 4;
  localparam int DEPTH = 4;
  localparam int DW = KW + VW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          s0_valid;
  logic [DW-1:0] s0_data;
  logic          s0_ready;
  logic          s1_valid;
  logic [DW-1:0] s1_data;
  logic          s1_ready;
  logic          pq_ivalid;
  logic [DW-1:0] pq_idata;
  logic          pq_full;
  logic [CW-1:0] count;
`ifdef PQ_INGRESS_STATS_EN
  logic [CW-1:0] hwm;
  logic [15:0]   stall_cnt;
  logic [15:0]   bp_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [DW-1:0] sb[$];

  pq_ingress #(.KW(KW), .VW(VW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .s0_valid (s0_valid),
    .s0_data  (s0_data),
    .s0_ready (s0_ready),
    .s1_valid (s1_valid),
    .s1_data  (s1_data),
    .s1_ready (s1_ready),
    .pq_ivalid(pq_ivalid),
    .pq_idata (pq_idata),
    .pq_full  (pq_full),
    .count    (count)
`ifdef PQ_INGRESS_STATS_EN
    ,
    .hwm      (hwm),
    .stall_cnt(stall_cnt),
    .bp_cnt   (bp_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted entries queued at the negedge before the push edge, popped on each insert.
  always @(negedge clk) begin
    if (rst_n && flush) begin
      sb.delete();
    end else if (rst_n) begin
      if (pq_ivalid && !pq_full) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", {24'd0, pq_idata}, 32'hFFFF_FFFF);
        end else begin
          chk("pop_order", {24'd0, pq_idata}, {24'd0, sb.pop_front()});
        end
      end
      if (s0_ready) sb.push_back(s0_data);
      if (s1_ready) sb.push_back(s1_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] exp_pop [4];
    exp_pop[0] = 8'hCC; exp_pop[1] = 8'h3D; exp_pop[2] = 8'hCC; exp_pop[3] = 8'h3D;

    rst_n = 1'b0; flush = 1'b0; pq_full = 1'b0;
    s0_valid = 1'b1; s0_data = 8'h11; s1_valid = 1'b0; s1_data = '0;
    #3;
    chk("rst_ivalid", {31'd0, pq_ivalid}, 32'd0);
    chk("rst_idata", {24'd0, pq_idata}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
    s0_valid = 1'b0;
    #9 rst_n = 1'b1;

    // single entry, pass-through latency
    tick();
    s0_valid = 1'b1; s0_data = 8'h4E;
    #1 chk("t1_s0_ready", {31'd0, s0_ready}, 32'd1);
    tick();
    s0_valid = 1'b0;
    #1;
    chk("t1_ivalid", {31'd0, pq_ivalid}, 32'd1);
    chk("t1_idata", {24'd0, pq_idata}, 32'h4E);
    chk("t1_count", {28'd0, count}, 32'd1);
    tick();
    #1;
    chk("t1_empty", {31'd0, pq_ivalid}, 32'd0);
    chk("t1_count0", {28'd0, count}, 32'd0);

    // re-reset so producer 0 wins the first tie
    rst_n = 1'b0; sb.delete();
    #2 rst_n = 1'b1;

    // round-robin fill against a full PQ
    tick();
    pq_full = 1'b1;
    s0_valid = 1'b1; s0_data = 8'hCC; s1_valid = 1'b1; s1_data = 8'h3D;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_s0_ready", {31'd0, s0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_s1_ready", {31'd0, s1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_count", {28'd0, count}, i);
      tick();
    end
    #1;
    chk("full_count", {28'd0, count}, 32'd4);
    chk("full_s0_ready", {31'd0, s0_ready}, 32'd0);
    chk("full_s1_ready", {31'd0, s1_ready}, 32'd0);
    chk("full_head", {24'd0, pq_idata}, 32'hCC);
    tick();
    chk("hold_head", {24'd0, pq_idata}, 32'hCC);
    chk("hold_ivalid", {31'd0, pq_ivalid}, 32'd1);

    // drain in acceptance order
    s0_valid = 1'b0; s1_valid = 1'b0; pq_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_ivalid", {31'd0, pq_ivalid}, 32'd1);
      chk("drain_idata", {24'd0, pq_idata}, {24'd0, exp_pop[i]});
      tick();
    end
    #1;
    chk("drain_empty", {31'd0, pq_ivalid}, 32'd0);
    chk("drain_count", {28'd0, count}, 32'd0);

    // steady push+pop at count=2 with pointer wrap
    pq_full = 1'b1;
    s1_valid = 1'b1; s1_data = 8'h1B;
    tick();
    s1_data = 8'h5F;
    tick();
    pq_full = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s1_data = (k % 2 == 0) ? 8'h1B : 8'h5F;
      #1;
      chk("wrap_count", {28'd0, count}, 32'd2);
      chk("wrap_head", {24'd0, pq_idata}, (k % 2 == 0) ? 32'h1B : 32'h5F);
      tick();
    end
    s1_valid = 1'b0;
    tick();
    tick();
    #1 chk("wrap_drained", {28'd0, count}, 32'd0);

    // asynchronous reset mid-cycle with count=3
    pq_full = 1'b1;
    s0_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s0_data = DW'(i);
      tick();
    end
    s0_valid = 1'b0;
    #1 chk("pre_rst_count", {28'd0, count}, 32'd3);
    rst_n = 1'b0; sb.delete();
    #1;
    chk("async_rst_count", {28'd0, count}, 32'd0);
    chk("async_rst_ivalid", {31'd0, pq_ivalid}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    pq_full = 1'b0;
    s0_valid = 1'b1; s0_data = 8'h77;
    tick();
    s0_valid = 1'b0;
    #1;
    chk("post_rst_idata", {24'd0, pq_idata}, 32'h77);
    chk("post_rst_ivalid", {31'd0, pq_ivalid}, 32'd1);
    tick();

    // flush with count=2 and a producer waiting
    pq_full = 1'b1;
    s0_valid = 1'b1; s0_data = 8'hA1;
    tick();
    s0_data = 8'hA2;
    tick();
    s0_data = 8'hA3; flush = 1'b1;
    #1;
    chk("flush_s0_ready", {31'd0, s0_ready}, 32'd0);
    chk("flush_count_pre", {28'd0, count}, 32'd2);
`ifdef PQ_INGRESS_STATS_EN
    chk("flush_hwm_pre", {28'd0, hwm}, 32'd2);
`endif
    tick();
    flush = 1'b0; s0_valid = 1'b0; pq_full = 1'b0;
    #1;
    chk("flush_count", {28'd0, count}, 32'd0);
    chk("flush_ivalid", {31'd0, pq_ivalid}, 32'd0);
`ifdef PQ_INGRESS_STATS_EN
    chk("flush_hwm", {28'd0, hwm}, 32'd0);
    chk("flush_stall", {16'd0, stall_cnt}, 32'd0);
`endif
    tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pq_ingress.md
Name: pq_ingress

Overview:
- Input stage directly upstream of the shift-register priority queue (sr_pq); drives its ivalid/idata insert port.
- Merges two producer streams through a round-robin arbiter into a small FIFO.
- Drains the FIFO into the PQ one entry per cycle, but only while the PQ reports not-full.
- Absorbs bursts and back-pressure so producers never see PQ capacity directly.

Parameters:
- KW, 4, key (priority) width; key occupies the upper bits of each entry.
- VW, 4, value width; value occupies the lower bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous FIFO clear; highest priority after reset.
- s0_valid  input  1  producer 0 offers an entry.
- s0_data  input  KW+VW  producer 0 entry, {key,value}.
- s0_ready  output  1  producer 0 entry accepted this cycle.
- s1_valid  input  1  producer 1 offers an entry.
- s1_data  input  KW+VW  producer 1 entry, {key,value}.
- s1_ready  output  1  producer 1 entry accepted this cycle.
- pq_ivalid  output  1  to PQ ivalid; high when the FIFO is non-empty.
- pq_idata  output  KW+VW  to PQ idata; the FIFO head entry.
- pq_full  input  1  PQ cannot accept an insert this cycle.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO emptied, read and write pointers cleared.
  - Arbiter last-grant pointer set to producer 1, so producer 0 wins the first tie.
  - Outputs while in reset: pq_ivalid=0, pq_idata=0, count=0, s0_ready=0, s1_ready=0.
  - Reset asserted mid-transfer discards all queued entries; no partial state survives.
- Push side:
  - ready outputs are combinational from FIFO full, the valids and the last-grant pointer.
  - FIFO full (count==DEPTH): both ready outputs low, even if a pop happens the same cycle.
  - Only s0_valid: s0_ready=1. Only s1_valid: s1_ready=1.
  - Both valid: grant the producer not granted last; the other producer's ready stays low.
  - Last-grant pointer updates only on an actual push.
  - At most one push per cycle. A producer holds valid and data stable until it sees ready.
- Pop side:
  - pq_ivalid=!empty; pq_idata=mem[rd_ptr], combinational from FIFO state with no output register.
  - Pop occurs when pq_ivalid && !pq_full; rd_ptr then advances.
  - pq_full=1 holds the head stable; pq_ivalid stays high.
- Latency: an entry pushed in cycle N appears on pq_ivalid/pq_idata in cycle N+1 at the earliest.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Empty FIFO: pop suppressed because pq_ivalid=0; a same-cycle push is visible next cycle (no bypass).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are decided from count, not from pointer equality.
- flush=1:
  - Clears pointers and count next edge; any push or pop that cycle is ignored.
  - Both ready outputs forced low while flush=1.
  - Arbiter pointer unchanged.
- Ordering: entries reach the PQ strictly in acceptance order. The block does no priority sorting; that is the PQ's job.

Optional Feature:
- Macro PQ_INGRESS_STATS_EN.
- When defined, three extra outputs:
  - hwm, $clog2(DEPTH)+1 bits: maximum count since reset or flush.
  - stall_cnt, 16 bits: counts cycles with pq_ivalid && pq_full; saturates at 16'hFFFF; cleared by reset or flush.
  - bp_cnt, 16 bits: counts cycles where any producer valid is high with its ready low; saturates; cleared by reset or flush.
- When undefined: ports and logic absent; core behaviour identical.

Test Plan:
- After reset, s0 offers {4'd4,4'd14} with pq_full=0 -> s0_ready=1; next cycle pq_ivalid=1, pq_idata={4'd4,4'd14}; following cycle pq_ivalid=0, count=0.
- s0 and s1 both hold valid every cycle, s0 data {4'd12,4'd12}, s1 data {4'd3,4'd13}, pq_full=1 -> grants alternate s0,s1,s0,s1; FIFO full at count=4; both ready low afterwards.
- Release pq_full from the full state -> four pops on consecutive cycles, in order {12,12},{3,13},{12,12},{3,13}; then pq_ivalid=0.
- s1 offers {4'd1,4'd11} and {4'd5,4'd15} on consecutive cycles, count=2, pq_full=0 -> push and pop each cycle; count stays 2; pointers wrap past DEPTH-1 with no data corruption.
- rst_n pulsed low for 3 ns mid-cycle with count=3 -> count=0 and pq_ivalid=0 immediately, without waiting for clk; first entry after release is the next accepted one.
- flush=1 with count=2 and s0_valid=1 -> s0_ready=0 and count=0 next cycle. With PQ_INGRESS_STATS_EN, hwm reports its pre-flush value until that edge, then 0.
